aer_spike_tx: RTL and testbench

Spike transmitter for one neuron tile. It takes the single-cycle fire pulse from the neuron data path, together with the neuron index supplied by the controller, and packs it into an AER packet stamped with the source tile coordinates and the current time step. Packets are buffered in a small FIFO and handed to the local router port over a valid/ready handshake. It sits between the data path spike output and the router injection port.

---
 rtl/aer_pkg.sv | 28 ++
 rtl/spike_fifo.sv | 54 +++++
 rtl/aer_spike_tx.sv | 91 +++++++++
 tb/tb_aer_spike_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - AER packet field defaults, offsets and the shared pack function
package aer_pkg;

  localparam int NURN_W_DEF = 8;
  localparam int X_W_DEF    = 4;
  localparam int Y_W_DEF    = 4;
  localparam int TICK_W_DEF = 16;
  localparam int AER_W_DEF  = 32;

  localparam int NURN_OFS_DEF = 0;
  localparam int TICK_OFS_DEF = NURN_OFS_DEF + NURN_W_DEF;
  localparam int Y_OFS_DEF    = TICK_OFS_DEF + TICK_W_DEF;
  localparam int X_OFS_DEF    = Y_OFS_DEF + Y_W_DEF;

  // Fields are zero-extended by the caller; offsets let the decoder side share this with other widths.
  function automatic logic [63:0] aer_pack(
    input logic [63:0] x_id,
    input logic [63:0] y_id,
    input logic [63:0] tick,
    input logic [63:0] nurn_idx,
    input int          tick_ofs,
    input int          y_ofs,
    input int          x_ofs
  );
    aer_pack = nurn_idx | (tick << tick_ofs) | (y_id << y_ofs) | (x_id << x_ofs);
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// rtl/spike_fifo.sv - generic synchronous register FIFO with count and head data
module spike_fifo #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [DSIZE-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  output logic [DSIZE-1:0] o_head
);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/aer_spike_tx.sv
// rtl/aer_spike_tx.sv - packs neuron spikes into AER packets and queues them for the router
module aer_spike_tx
  import aer_pkg::*;
#(
  parameter int NURN_CNT_BIT_WIDTH = NURN_W_DEF,
  parameter int X_ID_BIT_WIDTH     = X_W_DEF,
  parameter int Y_ID_BIT_WIDTH     = Y_W_DEF,
  parameter int TICK_BIT_WIDTH     = TICK_W_DEF,
  parameter int AER_BIT_WIDTH      = AER_W_DEF,
  parameter int FIFO_DEPTH         = 4,
  parameter int DROP_CNT_BIT_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [X_ID_BIT_WIDTH-1:0]     X_ID_i,
  input  logic [Y_ID_BIT_WIDTH-1:0]     Y_ID_i,
  input  logic                          tick_i,
  input  logic                          spike_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0] nurnIdx_i,
  output logic [AER_BIT_WIDTH-1:0]      aer_data_o,
  output logic                          aer_valid_o,
  input  logic                          aer_ready_i,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [DROP_CNT_BIT_WIDTH-1:0] dropCnt_o
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int TICK_OFS = NURN_CNT_BIT_WIDTH;
  localparam int Y_OFS    = TICK_OFS + TICK_BIT_WIDTH;
  localparam int X_OFS    = Y_OFS + Y_ID_BIT_WIDTH;

  logic [TICK_BIT_WIDTH-1:0]     r_tick_cnt;
  logic                          r_overflow;
  logic [DROP_CNT_BIT_WIDTH-1:0] r_drop_cnt;

  logic [AER_BIT_WIDTH-1:0] w_pkt;
  logic [AER_BIT_WIDTH-1:0] w_head;
  logic [AW:0]              w_count;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_space;
  logic                     w_push;
  logic                     w_drop;

  // Stamp uses the pre-increment tick count even when tick_i coincides with the spike.
  assign w_pkt = AER_BIT_WIDTH'(aer_pack(64'(X_ID_i), 64'(Y_ID_i), 64'(r_tick_cnt),
                                         64'(nurnIdx_i), TICK_OFS, Y_OFS, X_OFS));

  assign w_pop   = aer_valid_o & aer_ready_i;
  assign w_space = ~w_full | w_pop;
  assign w_push  = spike_i & w_space & ~rst_i;
  assign w_drop  = spike_i & ~w_space;

  spike_fifo #(
    .DSIZE (AER_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_data  (w_pkt),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tick_cnt <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (tick_i) r_tick_cnt <= r_tick_cnt + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign aer_valid_o = (w_count != '0);
  assign aer_data_o  = w_empty ? '0 : w_head;
  assign busy_o      = aer_valid_o;
  assign overflow_o  = r_overflow;
  assign dropCnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_aer_spike_tx.sv
// tb/tb_aer_spike_tx.sv - randomized and directed bench for aer_spike_tx against a queue model
module tb_aer_spike_tx;

  localparam int DEPTH   = 4;
  localparam int DCW     = 2;
  localparam int DCMAX   = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  X_ID_i;
  logic [3:0]  Y_ID_i;
  logic        tick_i;
  logic        spike_i;
  logic [7:0]  nurnIdx_i;
  logic [31:0] aer_data_o;
  logic        aer_valid_o;
  logic        aer_ready_i;
  logic        busy_o;
  logic        overflow_o;
  logic [DCW-1:0] dropCnt_o;

  aer_spike_tx #(
    .FIFO_DEPTH         (DEPTH),
    .DROP_CNT_BIT_WIDTH (DCW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .X_ID_i      (X_ID_i),
    .Y_ID_i      (Y_ID_i),
    .tick_i      (tick_i),
    .spike_i     (spike_i),
    .nurnIdx_i   (nurnIdx_i),
    .aer_data_o  (aer_data_o),
    .aer_valid_o (aer_valid_o),
    .aer_ready_i (aer_ready_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .dropCnt_o   (dropCnt_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] m_q[$];
  int unsigned m_tick = 0;
  int unsigned m_drops = 0;
  bit          m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_pkt(input int unsigned x, input int unsigned y,
                                          input int unsigned tick, input int unsigned idx);
    longint unsigned v;
    v = longint'(x) * 64'd268435456 + longint'(y) * 64'd16777216 + longint'(tick) * 64'd256 + longint'(idx);
    return v[31:0];
  endfunction

  // Advance the model by one clock using the currently driven inputs, then compare after the edge.
  task automatic step();
    bit          pop;
    bit          space;
    logic [31:0] pkt;
    if (rst_i) begin
      m_q.delete();
      m_tick  = 0;
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      pop   = (m_q.size() != 0) && aer_ready_i;
      space = (m_q.size() < DEPTH) || pop;
      pkt   = ref_pkt(X_ID_i, Y_ID_i, m_tick, nurnIdx_i);
      if (pop) void'(m_q.pop_front());
      if (spike_i) begin
        if (space) m_q.push_back(pkt);
        else begin
          m_ovf = 1'b1;
          if (m_drops < DCMAX) m_drops++;
        end
      end
      if (tick_i) m_tick = (m_tick + 1) % 65536;
    end
    @(posedge clk_i);
    #1;
    check_eq("valid", aer_valid_o, m_q.size() != 0);
    check_eq("busy", busy_o, m_q.size() != 0);
    check_eq("data", aer_data_o, (m_q.size() != 0) ? m_q[0] : 32'h0);
    check_eq("overflow", overflow_o, m_ovf);
    check_eq("drop_cnt", dropCnt_o, m_drops);
  endtask

  task automatic idle_inputs();
    tick_i      = 1'b0;
    spike_i     = 1'b0;
    nurnIdx_i   = 8'h00;
  endtask

  initial begin
    rst_i       = 1'b1;
    X_ID_i      = 4'd3;
    Y_ID_i      = 4'd5;
    aer_ready_i = 1'b1;
    idle_inputs();
    step();
    check_eq("rst_valid", aer_valid_o, 0);
    check_eq("rst_data", aer_data_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_drop", dropCnt_o, 0);
    rst_i = 1'b0;

    // single spike after seven ticks
    tick_i = 1'b1;
    for (int i = 0; i < 7; i++) step();
    tick_i = 1'b0; spike_i = 1'b1; nurnIdx_i = 8'h2A;
    step();
    check_eq("single_valid", aer_valid_o, 1);
    check_eq("single_data", aer_data_o, 32'h3500072A);
    idle_inputs();
    step();
    check_eq("single_gone", aer_valid_o, 0);

    // backpressure with one drop
    aer_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      spike_i = 1'b1; nurnIdx_i = 8'(k);
      step();
    end
    idle_inputs();
    check_eq("bp_ovf", overflow_o, 1);
    check_eq("bp_drop", dropCnt_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold", aer_data_o, 32'h35000701);
    end
    aer_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("bp_order", aer_data_o, 32'h35000700 + 32'(k));
      step();
    end
    check_eq("bp_empty", aer_valid_o, 0);

    // push while full with a simultaneous pop
    aer_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      spike_i = 1'b1; nurnIdx_i = 8'h11 + 8'(k);
      step();
    end
    aer_ready_i = 1'b1; spike_i = 1'b1; nurnIdx_i = 8'h99;
    step();
    check_eq("pf_no_drop", dropCnt_o, 1);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      check_eq("pf_order", aer_data_o, 32'h35000712 + 32'(k));
      step();
    end
    check_eq("pf_last", aer_data_o, 32'h35000799);
    step();
    check_eq("pf_empty", aer_valid_o, 0);

    // tick wrap with coincident spike
    aer_ready_i = 1'b0; tick_i = 1'b1;
    for (int i = 0; i < 65535 - 7; i++) step();
    spike_i = 1'b1; nurnIdx_i = 8'h55;
    step();
    check_eq("wrap_stamp", aer_data_o, 32'h35FFFF55);
    tick_i = 1'b0; nurnIdx_i = 8'h56;
    step();
    aer_ready_i = 1'b1; idle_inputs();
    step();
    check_eq("wrap_next", aer_data_o, 32'h35000056);
    step();

    // drop saturation, then reset while full
    aer_ready_i = 1'b0;
    for (int k = 0; k < 14; k++) begin
      spike_i = 1'b1; nurnIdx_i = 8'(k);
      step();
    end
    check_eq("sat_drop", dropCnt_o, 3);
    rst_i = 1'b1; nurnIdx_i = 8'hEE;
    step();
    check_eq("rst_full_valid", aer_valid_o, 0);
    check_eq("rst_full_ovf", overflow_o, 0);
    check_eq("rst_full_drop", dropCnt_o, 0);
    rst_i = 1'b0; nurnIdx_i = 8'h42;
    step();
    check_eq("post_rst_pkt", aer_data_o, 32'h35000042);
    idle_inputs();
    aer_ready_i = 1'b1;
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_i       = ($urandom_range(0, 199) == 0);
      tick_i      = ($urandom_range(0, 2) == 0);
      spike_i     = ($urandom_range(0, 1) == 0);
      nurnIdx_i   = 8'($urandom);
      aer_ready_i = ($urandom_range(0, 2) != 0) ? ($urandom_range(0, 1) == 0) : 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        X_ID_i = 4'($urandom);
        Y_ID_i = 4'($urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
